uart_rx_fifo: RTL and testbench

Parametrised UART receiver with a receive FIFO, the device-side RX path that pairs with the host-to-device serial stream driven into `uart_io`. It oversamples the serial line in the core clock domain and decodes start, data, optional parity and 1 or 2 stop bits. Received words are buffered in a show-ahead FIFO, and parity, framing and overrun errors are reported as sticky flags. It sits between the `uart_master_tx` pad and the core's register/RC interface.

---
 rtl/uart_rx_fifo.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (start/data/optional parity/1-2 stop) feeding a show-ahead receive buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 20_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int N_DATA_BITS = 8,
    parameter int LSB_FIRST   = 1,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            uart_rx,
    input  logic                            rd_en,
    output logic [N_DATA_BITS-1:0]          rd_data,
    output logic                            empty,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            rx_busy,
    output logic                            parity_err,
    output logic                            frame_err,
    output logic                            overrun_err,
    input  logic                            err_clr,
    output logic [2:0]                      dbg_state
);

    localparam int CPB  = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int HALF = CPB / 2;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [1:0]             r_fill;
    logic                   r_armed;
    logic [CW-1:0]          r_cnt;
    logic [3:0]             r_bit_idx;
    logic [N_DATA_BITS-1:0] r_shift;
    logic                   r_par;
    logic                   r_par_fail;
    logic                   r_stop_bad;
    logic                   r_parity_err;
    logic                   r_frame_err;
    logic                   r_overrun_err;

    logic                   w_rx_s;
    logic                   w_tick;
    logic                   w_last_stop;
    logic                   w_commit;
    logic                   w_frame_bad;
    logic                   w_push_req;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_overrun;

    // r_fill marks when r_sync2 holds a real line sample rather than its reset value,
    // so a line held low through reset never arms start detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_fill  <= {r_fill[0], 1'b1};
            if (r_fill[1] && r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_rx_s      = r_sync2;
    assign w_tick      = (r_cnt == CW'(HALF));
    assign w_last_stop = (r_bit_idx == 4'(STOP_BITS - 1));
    assign w_commit    = (r_state == S_STOP) && w_tick && w_last_stop;
    assign w_frame_bad = r_stop_bad || !w_rx_s;
    assign w_push_req  = w_commit && !w_frame_bad;

    // Every bit is sampled when the free-running bit counter reaches CPB/2, which is
    // mid-bit for all bits because the counter is only reloaded on the start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_par_fail <= 1'b0;
            r_stop_bad <= 1'b0;
        end else begin
            if (r_state == S_IDLE || r_cnt == CW'(CPB - 1)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_armed && !w_rx_s) begin
                        r_state    <= S_START;
                        r_bit_idx  <= '0;
                        r_par      <= 1'b0;
                        r_par_fail <= 1'b0;
                        r_stop_bad <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_state <= w_rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (LSB_FIRST != 0) begin
                            r_shift <= {w_rx_s, r_shift[N_DATA_BITS-1:1]};
                        end else begin
                            r_shift <= {r_shift[N_DATA_BITS-2:0], w_rx_s};
                        end
                        r_par <= r_par ^ w_rx_s;
                        if (r_bit_idx == 4'(N_DATA_BITS - 1)) begin
                            r_bit_idx <= '0;
                            r_state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_par_fail <= ((r_par ^ w_rx_s) != 1'(PARITY_ODD));
                        r_state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (!w_rx_s) begin
                            r_stop_bad <= 1'b1;
                        end
                        if (w_last_stop) begin
                            r_bit_idx <= '0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read side: rd_data is the head entry and is valid while empty is low; a pulse of
    // rd_en while empty is low consumes that entry on the same clock edge.
    assign w_pop     = rd_en && !w_empty;
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_overrun = w_push_req && w_full && !w_pop;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [N_DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CNTW-1:0]        r_count;

    assign w_full  = (r_count == CNTW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count   = r_count;
`else
    logic [N_DATA_BITS-1:0] r_hold;
    logic                   r_valid;

    assign w_full  = r_valid;
    assign w_empty = !r_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hold  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_hold  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rd_data = r_valid ? r_hold : '0;
    assign count   = {{(CNTW-1){1'b0}}, r_valid};
`endif

    // A new error event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_parity_err  <= (w_push_req && r_par_fail) || (r_parity_err && !err_clr);
            r_frame_err   <= (w_commit && w_frame_bad) || (r_frame_err && !err_clr);
            r_overrun_err <= w_overrun || (r_overrun_err && !err_clr);
        end
    end

    assign empty       = w_empty;
    assign full        = w_full;
    assign rx_busy     = (r_state != S_IDLE);
    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 LSB-first instance and a 7E2 MSB-first instance, CPB=16,
// checked against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;

    localparam int CPB = 16;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH_EFF = 16;
`else
    localparam int DEPTH_EFF = 1;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       rd_en_a = 1'b0;
    logic       rd_en_b = 1'b0;
    logic       err_clr_a = 1'b0;
    logic       err_clr_b = 1'b0;

    logic [7:0] rd_data_a;
    logic       empty_a, full_a, busy_a, perr_a, ferr_a, oerr_a;
    logic [4:0] count_a;
    logic [2:0] dbg_a;
    logic [6:0] rd_data_b;
    logic       empty_b, full_b, busy_b, perr_b, ferr_b, oerr_b;
    logic [2:0] count_b;
    logic [2:0] dbg_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic       m_frame = 1'b0;
    logic       m_over  = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_FREQ_HZ(20_000_000), .BAUD_RATE(1_250_000), .N_DATA_BITS(8),
        .LSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) dut_a (
        .clk(clk), .rstn(rstn), .uart_rx(rx_a), .rd_en(rd_en_a), .rd_data(rd_data_a),
        .empty(empty_a), .full(full_a), .count(count_a), .rx_busy(busy_a),
        .parity_err(perr_a), .frame_err(ferr_a), .overrun_err(oerr_a),
        .err_clr(err_clr_a), .dbg_state(dbg_a)
    );

    uart_rx_fifo #(
        .CLK_FREQ_HZ(20_000_000), .BAUD_RATE(1_250_000), .N_DATA_BITS(7),
        .LSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .rstn(rstn), .uart_rx(rx_b), .rd_en(rd_en_b), .rd_data(rd_data_b),
        .empty(empty_b), .full(full_b), .count(count_b), .rx_busy(busy_b),
        .parity_err(perr_b), .frame_err(ferr_b), .overrun_err(oerr_b),
        .err_clr(err_clr_b), .dbg_state(dbg_b)
    );

    initial begin
        repeat (400000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input int sel, input logic [15:0] bits, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (sel == 0) rx_a = bits[i];
            else          rx_b = bits[i];
            repeat (CPB - 1) @(negedge clk);
        end
        if (sel == 0) rx_a = 1'b1;
        else          rx_b = 1'b1;
    endtask

    function automatic logic [15:0] frame_a(input logic [7:0] d, input logic stop);
        return {6'b0, stop, d, 1'b0};
    endfunction

    // MSB first, even parity over the 7 data bits, then two stop bits.
    function automatic logic [15:0] frame_b(input logic [6:0] d, input logic flip, input logic stop2);
        logic [15:0] f;
        f = '0;
        for (int i = 0; i < 7; i++) f[1+i] = d[6-i];
        f[8]  = (^d) ^ flip;
        f[9]  = 1'b1;
        f[10] = stop2;
        return f;
    endfunction

    task automatic model_a(input logic [7:0] d, input logic stop_ok);
        if (!stop_ok)                       m_frame = 1'b1;
        else if (exp_q.size() == DEPTH_EFF) m_over  = 1'b1;
        else                                exp_q.push_back(d);
    endtask

    task automatic send_a(input logic [7:0] d, input logic stop_ok);
        send_bits(0, frame_a(d, stop_ok), 10);
        model_a(d, stop_ok);
    endtask

    task automatic pop_a();
        @(negedge clk); rd_en_a = 1'b1;
        @(negedge clk); rd_en_a = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic clr_a();
        @(negedge clk); err_clr_a = 1'b1;
        @(negedge clk); err_clr_a = 1'b0;
        m_frame = 1'b0;
        m_over  = 1'b0;
    endtask

    task automatic check_a(input string tag);
        check({tag, ".count"}, 32'(count_a), 32'(exp_q.size()));
        check({tag, ".empty"}, 32'(empty_a), 32'(exp_q.size() == 0));
        check({tag, ".full"},  32'(full_a),  32'(exp_q.size() == DEPTH_EFF));
        if (exp_q.size() > 0) check({tag, ".rd_data"}, 32'(rd_data_a), 32'(exp_q[0]));
        check({tag, ".frame_err"},   32'(ferr_a), 32'(m_frame));
        check({tag, ".overrun_err"}, 32'(oerr_a), 32'(m_over));
        check({tag, ".parity_err"},  32'(perr_a), 32'd0);
        check({tag, ".rx_busy"},     32'(busy_a), 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       pop_before;
        logic       exp_empty;
        logic [4:0] exp_count;
        logic [7:0] exp_head;
        logic       exp_frame;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 5'd1, 8'hA5, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 5'd1, 8'hA5, 1'b1};
        tbl[2] = '{8'h5A, 1'b1, 1'b1, 1'b0, 5'd1, 8'h5A, 1'b1};
        tbl[3] = '{8'hC3, 1'b1, 1'b1, 1'b0, 5'd1, 8'hC3, 1'b1};
        tbl[4] = '{8'h81, 1'b0, 1'b1, 1'b1, 5'd0, 8'h00, 1'b1};

        gap(5);
        check("rst.rd_data_a", 32'(rd_data_a), 32'd0);
        check("rst.empty_a",   32'(empty_a),   32'd1);
        check("rst.full_a",    32'(full_a),    32'd0);
        check("rst.count_a",   32'(count_a),   32'd0);
        check("rst.busy_a",    32'(busy_a),    32'd0);
        check("rst.flags_a",   32'({perr_a, ferr_a, oerr_a}), 32'd0);
        check("rst.empty_b",   32'(empty_b),   32'd1);
        check("rst.flags_b",   32'({perr_b, ferr_b, oerr_b}), 32'd0);
        rstn = 1'b1;
        gap(10);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].pop_before) pop_a();
            send_a(tbl[i].data, tbl[i].stop_ok);
            gap(3 * CPB);
            check($sformatf("tbl%0d.count", i), 32'(count_a), 32'(tbl[i].exp_count));
            check($sformatf("tbl%0d.empty", i), 32'(empty_a), 32'(tbl[i].exp_empty));
            if (!tbl[i].exp_empty)
                check($sformatf("tbl%0d.rd_data", i), 32'(rd_data_a), 32'(tbl[i].exp_head));
            check($sformatf("tbl%0d.frame_err", i), 32'(ferr_a), 32'(tbl[i].exp_frame));
        end
        clr_a();
        gap(2);
        check_a("clr");

        @(negedge clk); rx_a = 1'b0;
        gap(5);
        rx_a = 1'b1;
        gap(3 * CPB);
        check_a("glitch");

        for (int i = 0; i <= 16; i++) send_a(8'(i), 1'b1);
        gap(3 * CPB);
        check_a("overrun");
        check("overrun.flag", 32'(oerr_a), 32'd1);
        for (int i = 0; i < DEPTH_EFF; i++) begin
            check($sformatf("drain%0d", i), 32'(rd_data_a), 32'(i));
            pop_a();
        end
        gap(2);
        check_a("drained");

        clr_a();
        for (int i = 0; i < DEPTH_EFF; i++) send_a(8'h40 + 8'(i), 1'b1);
        gap(3 * CPB);
        check_a("prefull");
        fork
            send_bits(0, frame_a(8'h77, 1'b1), 10);
            begin
                @(negedge clk);
                repeat (155) @(posedge clk);
                #1 rd_en_a = 1'b1;
                @(posedge clk);
                #1 rd_en_a = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        exp_q.push_back(8'h77);
        gap(3 * CPB);
        check_a("pushpop_full");
        while (exp_q.size() > 0) begin
            pop_a();
            gap(1);
            check_a("pushpop_drain");
        end

        for (int b = 0; b < 8; b++) begin
            int nf;
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++)
                send_a(8'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0));
            gap(3 * CPB);
            check_a($sformatf("rnd%0d", b));
            for (int p = $urandom_range(0, 2); p > 0; p--) pop_a();
            gap(1);
            check_a($sformatf("rndpop%0d", b));
            if ($urandom_range(0, 1) == 1) clr_a();
        end

        send_bits(1, frame_b(7'h55, 1'b0, 1'b1), 11);
        gap(3 * CPB);
        check("b.good.count",   32'(count_b),   32'd1);
        check("b.good.rd_data", 32'(rd_data_b), 32'h55);
        check("b.good.flags",   32'({perr_b, ferr_b, oerr_b}), 32'd0);
        @(negedge clk); rd_en_b = 1'b1;
        @(negedge clk); rd_en_b = 1'b0;
        send_bits(1, frame_b(7'h55, 1'b1, 1'b1), 11);
        gap(3 * CPB);
        check("b.par.count",   32'(count_b),   32'd1);
        check("b.par.rd_data", 32'(rd_data_b), 32'h55);
        check("b.par.perr",    32'(perr_b),    32'd1);
        @(negedge clk); err_clr_b = 1'b1;
        @(negedge clk); err_clr_b = 1'b0;
        check("b.clr.perr", 32'(perr_b), 32'd0);
        @(negedge clk); rd_en_b = 1'b1;
        @(negedge clk); rd_en_b = 1'b0;
        send_bits(1, frame_b(7'h2A, 1'b0, 1'b0), 11);
        gap(3 * CPB);
        check("b.stop2.ferr",  32'(ferr_b),  32'd1);
        check("b.stop2.count", 32'(count_b), 32'd0);

        @(negedge clk); rx_a = 1'b0;
        gap(40);
        rstn = 1'b0;
        gap(3);
        check("mid.rd_data", 32'(rd_data_a), 32'd0);
        check("mid.empty",   32'(empty_a),   32'd1);
        check("mid.count",   32'(count_a),   32'd0);
        check("mid.busy",    32'(busy_a),    32'd0);
        check("mid.flags",   32'({perr_a, ferr_a, oerr_a}), 32'd0);
        exp_q.delete();
        m_frame = 1'b0;
        m_over  = 1'b0;
        rstn = 1'b1;
        gap(40);
        check("lowline.busy",  32'(busy_a),  32'd0);
        check("lowline.empty", 32'(empty_a), 32'd1);
        rx_a = 1'b1;
        gap(20);
        send_a(8'h3C, 1'b1);
        gap(3 * CPB);
        check_a("after_rst");
        pop_a();
        gap(1);
        check_a("after_rst_pop");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
